// File: rtl/rs_corr_sched_pkg.sv
// rs_corr_sched_pkg: shared widths, read-FSM encoding and correction-pipe gap for the RS correction scheduler.
package rs_corr_sched_pkg;
  localparam int SYM_BW_BW = 4;
  localparam int R_BW = 5;
  localparam int CORR_PIPE_GAP = 2;
  typedef enum logic [2:0] {IDLE, START, GAP1, GAP2, PLAY} state_e;
endpackage

// File: rtl/rs_pingpong_ram.sv
// rs_pingpong_ram: simple dual-port symbol RAM, one write port and one registered read port.
module rs_pingpong_ram #(
  parameter int SYM_BW = 8,
  parameter int DEPTH = 510,
  parameter int AW = 9
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [SYM_BW-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [SYM_BW-1:0] rdata_o
);
  logic [SYM_BW-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/rs_corr_sched.sv
// rs_corr_sched: ping-pong codeword buffer that captures decoder results per bank and
// replays each block to the correction stage after a start pulse and two gap cycles.
module rs_corr_sched
  import rs_corr_sched_pkg::*;
#(
  parameter int SYM_BW = 8,
  parameter int N_NUM = 255,
  parameter int T_NUM = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_val,
  input  logic [SYM_BW-1:0]        in_sym,
  output logic                     in_rdy,
  input  logic                     res_val,
  input  logic                     res_fail,
  input  logic [SYM_BW*T_NUM-1:0]  res_err_loc,
  input  logic [SYM_BW*T_NUM-1:0]  res_err_val,
  output logic                     corr_start,
  output logic [SYM_BW*T_NUM-1:0]  corr_err_loc,
  output logic [SYM_BW*T_NUM-1:0]  corr_err_val,
  output logic [SYM_BW-1:0]        symb_cnt,
  output logic [SYM_BW-1:0]        symb_with_err,
  output logic                     blk_fail,
  output logic                     res_orphan
);
  localparam int LW = SYM_BW*T_NUM;
  localparam int AW = $clog2(2*N_NUM);
  localparam logic [SYM_BW-1:0] N_LAST = SYM_BW'(N_NUM);
  state_e state_q, state_d;
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, res_bank_q, res_bank_d;
  logic [SYM_BW-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [1:0] full_q, full_d, resolved_q, resolved_d, fail_q, fail_d;
  logic [LW-1:0] loc_q [2], loc_d [2], val_q [2], val_d [2];
  logic [LW-1:0] corr_loc_q, corr_loc_d, corr_val_q, corr_val_d;
  logic orphan_q, orphan_d, res_ok, rd_ready;
  logic wr_fire, play_done, rd_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [SYM_BW-1:0] rd_data;
  assign in_rdy = !full_q[wr_bank_q];
  assign wr_fire = in_val && in_rdy;
  assign play_done = state_q == PLAY && rd_cnt_q == N_LAST;
  // The read for count c+1 is issued while count c is on the outputs (GAP2 issues count 1).
  assign rd_en = state_q == GAP2 || (state_q == PLAY && !play_done);
  assign wr_addr = AW'(wr_bank_q ? N_NUM : 0) + AW'(wr_cnt_q) - AW'(1);
  assign rd_addr = AW'(rd_bank_q ? N_NUM : 0) + AW'(rd_cnt_q);
  rs_pingpong_ram #(.SYM_BW(SYM_BW), .DEPTH(2*N_NUM), .AW(AW)) u_ram (
    .clk(clk), .we_i(wr_fire), .waddr_i(wr_addr), .wdata_i(in_sym),
    .re_i(rd_en), .raddr_i(rd_addr), .rdata_o(rd_data)
  );
  always_comb begin
    state_d = state_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    res_bank_d = res_bank_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    full_d = full_q;
    resolved_d = resolved_q;
    fail_d = fail_q;
    loc_d = loc_q;
    val_d = val_q;
    corr_loc_d = corr_loc_q;
    corr_val_d = corr_val_q;
    if (wr_fire) begin
      wr_cnt_d = wr_cnt_q == N_LAST ? SYM_BW'(1) : wr_cnt_q + 1'b1;
      if (wr_cnt_q == N_LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d = !wr_bank_q;
      end
    end
    if (play_done) begin
      full_d[rd_bank_q] = 1'b0;
      resolved_d[rd_bank_q] = 1'b0;
      fail_d[rd_bank_q] = 1'b0;
      rd_bank_d = !rd_bank_q;
    end
    // Acceptance looks at next-state full so a result arriving with the last symbol is kept.
    res_ok = res_val && full_d[res_bank_q] && !resolved_q[res_bank_q];
    orphan_d = res_val && !res_ok;
    if (res_ok) begin
      loc_d[res_bank_q] = res_fail ? '0 : res_err_loc;
      val_d[res_bank_q] = res_err_val;
      fail_d[res_bank_q] = res_fail;
      resolved_d[res_bank_q] = 1'b1;
      res_bank_d = !res_bank_q;
    end
    rd_ready = full_d[rd_bank_d] && resolved_d[rd_bank_d];
    case (state_q)
      IDLE: state_d = rd_ready ? START : IDLE;
      START: state_d = GAP1;
      GAP1: state_d = GAP2;
      GAP2: begin
        state_d = PLAY;
        rd_cnt_d = SYM_BW'(1);
      end
      PLAY: begin
        rd_cnt_d = play_done ? '0 : rd_cnt_q + 1'b1;
        if (play_done) state_d = rd_ready ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == START) begin
      corr_loc_d = loc_d[rd_bank_d];
      corr_val_d = val_d[rd_bank_d];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      res_bank_q <= 1'b0;
      wr_cnt_q <= SYM_BW'(1);
      rd_cnt_q <= '0;
      full_q <= '0;
      resolved_q <= '0;
      fail_q <= '0;
      loc_q <= '{default: '0};
      val_q <= '{default: '0};
      corr_loc_q <= '0;
      corr_val_q <= '0;
      orphan_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      res_bank_q <= res_bank_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      full_q <= full_d;
      resolved_q <= resolved_d;
      fail_q <= fail_d;
      loc_q <= loc_d;
      val_q <= val_d;
      corr_loc_q <= corr_loc_d;
      corr_val_q <= corr_val_d;
      orphan_q <= orphan_d;
    end
  end
  assign corr_start = state_q == START;
  assign corr_err_loc = corr_loc_q;
  assign corr_err_val = corr_val_q;
  assign symb_cnt = rd_cnt_q;
  assign symb_with_err = state_q == PLAY ? rd_data : '0;
  assign blk_fail = state_q == PLAY && fail_q[rd_bank_q];
  assign res_orphan = orphan_q;
endmodule
